ex_div_sequencer: RTL and testbench
===================================

// Module: ex_div_sequencer
// PURPOSE
//  Multi-cycle integer divide sequencer attached beside the single-cycle EX ALU. It accepts a
//  DIV/DIVU request from EX, freezes the pipeline via stall_req, and runs a radix-2 restoring
//  divide for DATA_WIDTH iterations. It then hands quotient/remainder back for WB as a one-cycle done pulse.
//  It also handles flush, divide-by-zero and the signed-overflow corner deterministically.
// PARAMETERS
//  DATA_WIDTH  32  operand/result width; must match `DATA_BUS
//  CNT_WIDTH    6  iteration counter width; must satisfy 2**CNT_WIDTH > DATA_WIDTH
// PORTS
//  clk          in   1           clock, all state on rising edge
//  rst          in   1           asynchronous, active-low reset
//  start        in   1           EX presents a divide this cycle (level, sampled only in IDLE)
//  signed_op    in   1           1 = DIV (two's complement), 0 = DIVU
//  dividend     in   DATA_WIDTH  operand_1 from EX
//  divisor      in   DATA_WIDTH  operand_2 from EX
//  flush        in   1           pipeline flush; aborts any operation in flight
//  stall_req    out  1           hold PC/IF/ID/EX while divide is in progress (combinational)
//  busy         out  1           state is neither IDLE nor DONE (registered)
//  done         out  1           one-cycle pulse: quotient/remainder valid
//  div_by_zero  out  1           qualifies done: divisor was zero
//  quotient     out  DATA_WIDTH  result; held stable from done until the next accepted start
//  remainder    out  DATA_WIDTH  result; held stable from done until the next accepted start
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, counter=0, quotient=0, remainder=0, done=0, busy=0,
//   div_by_zero=0. stall_req=0 when start=0.
//  States: IDLE -> PREP -> RUN -> FIX -> DONE -> IDLE.
//  - IDLE: start=1 & divisor!=0 -> PREP. The block latches operand magnitudes (abs if signed_op),
//    q_neg=sign(dividend)^sign(divisor) and r_neg=sign(dividend) when signed_op, and signed_op itself.
//    start=1 & divisor==0 -> DONE directly with quotient=all-ones, remainder=dividend, div_by_zero=1.
//  - PREP: clear partial remainder, counter=0 -> RUN.
//  - RUN: one restoring step per cycle: shift {rem,dvd} left 1; if rem>=dsr then rem-=dsr and set the quotient LSB.
//    counter++; after DATA_WIDTH steps (counter==DATA_WIDTH-1 on the edge) -> FIX.
//  - FIX: negate quotient if q_neg, negate remainder if r_neg (two's complement, mod 2**DATA_WIDTH) -> DONE.
//  - DONE: done=1 for exactly this cycle, then unconditionally -> IDLE; a start in DONE is not accepted.
//  Latency: start sampled in cycle 0 -> done=1 in cycle DATA_WIDTH+3 (35 for default);
//   divide-by-zero -> done=1 in cycle 1.
//  stall_req = (state==IDLE & start & !flush) | state in {PREP,RUN,FIX}; it is low in DONE,
//   so EX advances in the same cycle the result is consumed.
//  Overflow: signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0; no flag,
//   arises naturally from magnitude path, no special case.
//  flush=1 in any state -> IDLE on the next edge. done is not asserted for the aborted op, and
//   quotient/remainder keep their previous values. flush takes priority over start in the same cycle.
//  A start arriving while busy is ignored. Operands are captured only in IDLE, so later EX input changes have no effect.
//  rst asserted mid-operation -> immediate return to reset values.
// STRUCTURE
//  - Shared headers: state encodings (DIV_IDLE..DIV_DONE, 3-bit) and FUNCT_DIV/FUNCT_DIVU go in funct.v.
//    `DATA_BUS comes from bus.v.
//  - Sub-module div_restoring_step (combinational): inputs {rem, dvd_msb, dsr}, outputs
//    {next_rem, q_bit}; instantiated once and reused across RUN cycles.
//  - FSM, counter, sign/negate logic and output registers live in this module.
// TESTING
//  1. DIVU 100/7, start 1 cycle -> stall_req 1 for cycles 0..34, done in cycle 35, q=14, r=2.
//  2. DIV -7/2 -> q=0xFFFFFFFD(-3), r=0xFFFFFFFF(-1). DIV 7/-2 -> q=-3, r=1.
//  3. DIV 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0, div_by_zero=0.
//  4. DIVU 5/0 -> done in cycle 1, div_by_zero=1, q=0xFFFFFFFF, r=5.
//  5. Start DIVU 100/7, flush in cycle 10 -> IDLE in cycle 11, no done pulse, q/r keep prior values.
//     A new start in cycle 11 completes normally.
//  6. rst low in cycle 20 of a divide -> outputs zero immediately. Also: start held high through
//     DONE -> exactly one done pulse per accepted start, and the next op begins from IDLE.

Source files
------------

// File: rtl/ex_div_sequencer_pkg.sv
// rtl/ex_div_sequencer_pkg.sv - shared encodings for the EX-stage divide sequencer
//
// Purpose: divide FSM state encoding and the DIV/DIVU function codes decoded by EX.
// Ports:   none (package).
package ex_div_sequencer_pkg;

  typedef enum logic [2:0] {
    DIV_IDLE = 3'd0,
    DIV_PREP = 3'd1,
    DIV_RUN  = 3'd2,
    DIV_FIX  = 3'd3,
    DIV_DONE = 3'd4
  } div_state_e;

  localparam logic [5:0] FUNCT_DIV  = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU = 6'b011011;

endpackage

// File: rtl/ex_div_sequencer_step.sv
// rtl/ex_div_sequencer_step.sv - one radix-2 restoring divide iteration
//
// Purpose: shifts the next dividend bit into the partial remainder and subtracts the divisor
//          when it fits.
// Ports:   rem      in  partial remainder (always < dsr on entry)
//          dvd_msb  in  dividend bit shifted in this step
//          dsr      in  divisor magnitude
//          next_rem out updated partial remainder
//          q_bit    out quotient bit produced by this step
module div_restoring_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rem,
  input  logic                  dvd_msb,
  input  logic [DATA_WIDTH-1:0] dsr,
  output logic [DATA_WIDTH-1:0] next_rem,
  output logic                  q_bit
);

  // One extra bit: the shifted remainder can reach 2*dsr-1, which may exceed DATA_WIDTH bits.
  logic [DATA_WIDTH:0] trial;

  always_comb begin
    trial = {rem, dvd_msb};
    q_bit = (trial >= {1'b0, dsr});
    // After a successful subtract the result is below dsr, so truncation loses nothing.
    next_rem = q_bit ? DATA_WIDTH'(trial - {1'b0, dsr}) : trial[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/ex_div_sequencer.sv
// rtl/ex_div_sequencer.sv - multi-cycle DIV/DIVU sequencer beside the EX ALU
//
// Purpose: accepts a divide from EX, stalls the pipeline, runs DATA_WIDTH restoring steps,
//          fixes signs and presents quotient/remainder with a one-cycle done pulse.
// Ports:   clk, rst (async active-low)
//          start, signed_op, dividend, divisor  request from EX (sampled in IDLE only)
//          flush                                 abort any operation in flight
//          stall_req                             hold front of pipeline (combinational)
//          busy                                  PREP/RUN/FIX in progress (registered)
//          done, div_by_zero                     result valid pulse and its zero-divisor qualifier
//          quotient, remainder                   results, held until the next result is written
module ex_div_sequencer
  import ex_div_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  signed_op,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  input  logic                  flush,
  output logic                  stall_req,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder
);

  localparam logic [CNT_WIDTH-1:0] LAST_STEP = CNT_WIDTH'(DATA_WIDTH - 1);

  div_state_e            state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;       // partial remainder
  logic [DATA_WIDTH-1:0] dvd_q, dvd_d;       // dividend magnitude, becomes quotient as it shifts
  logic [DATA_WIDTH-1:0] dsr_q, dsr_d;       // divisor magnitude
  logic                  q_neg_q, q_neg_d;
  logic                  r_neg_q, r_neg_d;
  logic                  op_signed_q, op_signed_d;
  logic [DATA_WIDTH-1:0] quotient_q, quotient_d;
  logic [DATA_WIDTH-1:0] remainder_q, remainder_d;
  logic                  dbz_q, dbz_d;
  logic                  busy_q, busy_d;

  logic [DATA_WIDTH-1:0] step_rem;
  logic                  step_q_bit;

  div_restoring_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .rem      (rem_q),
    .dvd_msb  (dvd_q[DATA_WIDTH-1]),
    .dsr      (dsr_q),
    .next_rem (step_rem),
    .q_bit    (step_q_bit)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    dvd_d       = dvd_q;
    dsr_d       = dsr_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    op_signed_d = op_signed_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    // Flush wins over everything, including a start or a result write in the same cycle.
    if (flush) begin
      state_d = DIV_IDLE;
    end else begin
      unique case (state_q)
        DIV_IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              state_d     = DIV_DONE;
              quotient_d  = '1;
              remainder_d = dividend;
              dbz_d       = 1'b1;
            end else begin
              state_d     = DIV_PREP;
              // abs() of the most negative value is still correct when read as unsigned.
              dvd_d       = (signed_op && dividend[DATA_WIDTH-1]) ? -dividend : dividend;
              dsr_d       = (signed_op && divisor[DATA_WIDTH-1])  ? -divisor  : divisor;
              q_neg_d     = dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1];
              r_neg_d     = dividend[DATA_WIDTH-1];
              op_signed_d = signed_op;
              dbz_d       = 1'b0;
            end
          end
        end
        DIV_PREP: begin
          rem_d   = '0;
          cnt_d   = '0;
          state_d = DIV_RUN;
        end
        DIV_RUN: begin
          rem_d = step_rem;
          dvd_d = {dvd_q[DATA_WIDTH-2:0], step_q_bit};
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (cnt_q == LAST_STEP) begin
            state_d = DIV_FIX;
          end
        end
        DIV_FIX: begin
          quotient_d  = (op_signed_q && q_neg_q) ? -dvd_q : dvd_q;
          remainder_d = (op_signed_q && r_neg_q) ? -rem_q : rem_q;
          state_d     = DIV_DONE;
        end
        DIV_DONE: begin
          state_d = DIV_IDLE;
        end
        default: begin
          state_d = DIV_IDLE;
        end
      endcase
    end

    busy_d = (state_d == DIV_PREP) || (state_d == DIV_RUN) || (state_d == DIV_FIX);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= DIV_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      op_signed_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      dsr_q       <= dsr_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      op_signed_q <= op_signed_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      busy_q      <= busy_d;
    end
  end

  // Low in DONE so EX advances in the same cycle the result is consumed.
  assign stall_req   = ((state_q == DIV_IDLE) && start && !flush) ||
                       (state_q == DIV_PREP) || (state_q == DIV_RUN) || (state_q == DIV_FIX);
  assign busy        = busy_q;
  assign done        = (state_q == DIV_DONE);
  assign div_by_zero = dbz_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;

endmodule

// File: tb/tb_ex_div_sequencer.sv
// tb/tb_ex_div_sequencer.sv - directed self-checking bench for ex_div_sequencer
module tb_ex_div_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        flush;
  logic        stall_req;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int n_checks;
  int n_errors;

  ex_div_sequencer #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .flush       (flush),
    .stall_req   (stall_req),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .quotient    (quotient),
    .remainder   (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; that cycle is cycle 0. Returns the cycle in which done was seen
  // (-1 on timeout) and the number of cycles where stall_req disagreed with "high until done".
  task automatic do_op(input logic sop, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int stall_err);
    signed_op = sop;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    #1;
    stall_err = (stall_req !== 1'b1) ? 1 : 0;
    lat = -1;
    for (int c = 1; c <= 100 && lat < 0; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (done === 1'b1) begin
        lat = c;
        if (stall_req !== 1'b0) stall_err++;
      end else if (stall_req !== 1'b1) begin
        stall_err++;
      end
    end
  endtask

  typedef struct {
    string       tag;
    logic        sop;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[6];
  int   lat;
  int   stall_err;
  int   pulses;
  int   first_done;
  int   second_done;

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b0;
    start     = 1'b0;
    signed_op = 1'b0;
    dividend  = '0;
    divisor   = '0;
    flush     = 1'b0;

    vecs[0] = '{"divu_100_7",    1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 35};
    vecs[1] = '{"div_m7_2",      1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 35};
    vecs[2] = '{"div_7_m2",      1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 35};
    vecs[3] = '{"div_ovf",       1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 35};
    vecs[4] = '{"divu_big",      1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0, 35};
    vecs[5] = '{"divu_5_0",      1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 1};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    check("rst_stall", 32'(stall_req), 32'd0);
    check("rst_q", quotient, 32'd0);
    check("rst_r", remainder, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Directed operations, including the signed overflow and divide-by-zero corners
    foreach (vecs[i]) begin
      @(negedge clk);
      do_op(vecs[i].sop, vecs[i].a, vecs[i].b, lat, stall_err);
      check({vecs[i].tag, "_lat"}, 32'(lat), 32'(vecs[i].lat));
      check({vecs[i].tag, "_stall"}, 32'(stall_err), 32'd0);
      check({vecs[i].tag, "_q"}, quotient, vecs[i].q);
      check({vecs[i].tag, "_r"}, remainder, vecs[i].r);
      check({vecs[i].tag, "_dbz"}, 32'(div_by_zero), 32'(vecs[i].dbz));
    end

    // Flush in cycle 10 aborts: results from the divide-by-zero op above must survive
    @(negedge clk);
    signed_op = 1'b0;
    dividend  = 32'd100;
    divisor   = 32'd7;
    start     = 1'b1;
    pulses    = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (done === 1'b1) pulses++;
      if (c == 5) check("flush_busy_mid", 32'(busy), 32'd1);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_no_done", 32'(pulses), 32'd0);
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_done", 32'(done), 32'd0);
    check("flush_q_kept", quotient, 32'hFFFF_FFFF);
    check("flush_r_kept", remainder, 32'd5);
    do_op(1'b0, 32'd1000, 32'd10, lat, stall_err);
    check("after_flush_lat", 32'(lat), 32'd35);
    check("after_flush_q", quotient, 32'd100);
    check("after_flush_r", remainder, 32'd0);
    check("after_flush_dbz", 32'(div_by_zero), 32'd0);

    // Asynchronous reset in cycle 20 of a divide
    @(negedge clk);
    signed_op = 1'b0;
    dividend  = 32'd100;
    divisor   = 32'd7;
    start     = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_stall", 32'(stall_req), 32'd0);
    check("midrst_q", quotient, 32'd0);
    check("midrst_r", remainder, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // start held through DONE: one pulse per accepted start, next op restarts from IDLE
    @(negedge clk);
    signed_op   = 1'b0;
    dividend    = 32'd100;
    divisor     = 32'd7;
    start       = 1'b1;
    pulses      = 0;
    first_done  = -1;
    second_done = -1;
    for (int c = 1; c <= 72; c++) begin
      @(negedge clk);
      #1;
      if (done === 1'b1) begin
        pulses++;
        if (first_done < 0) first_done = c;
        else if (second_done < 0) second_done = c;
      end
    end
    start = 1'b0;
    check("hold_pulses", 32'(pulses), 32'd2);
    check("hold_first", 32'(first_done), 32'd35);
    check("hold_second", 32'(second_done), 32'd71);
    @(negedge clk);
    #1;
    check("hold_idle_busy", 32'(busy), 32'd0);
    check("hold_idle_done", 32'(done), 32'd0);
    check("hold_q", quotient, 32'd14);
    check("hold_r", remainder, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
